// File: rtl/traffic_phase_controller.sv
// Intersection phase sequencer: loads the shared interval timer and drives the lamp outputs.
// Optional flashing night mode is compiled in when TRAFFIC_FLASH_MODE_EN is defined.
module traffic_phase_controller #(
    parameter int T_BASE = 6,
    parameter int T_EXT  = 4,
    parameter int T_YEL  = 2
) (
    input  logic       clk,
    input  logic       sys_reset,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       night_mode,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] timer_value,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk
);

    // A zero load would wrap the 4-bit timer to 16 ticks.
    if (T_BASE < 1 || T_BASE > 15) begin : g_bad_base
        $error("traffic_phase_controller: T_BASE must be in 1..15");
    end
    if (T_EXT < 1 || T_EXT > 15) begin : g_bad_ext
        $error("traffic_phase_controller: T_EXT must be in 1..15");
    end
    if (T_YEL < 1 || T_YEL > 15) begin : g_bad_yel
        $error("traffic_phase_controller: T_YEL must be in 1..15");
    end

    localparam logic [3:0] BASE_VAL = 4'(T_BASE);
    localparam logic [3:0] EXT_VAL  = 4'(T_EXT);
    localparam logic [3:0] YEL_VAL  = 4'(T_YEL);

    typedef enum logic [2:0] {
        MAIN_GRN  = 3'd0,
        MAIN_HOLD = 3'd1,
        MAIN_YEL  = 3'd2,
        WALK      = 3'd3,
        SIDE_GRN  = 3'd4,
        SIDE_YEL  = 3'd5
`ifdef TRAFFIC_FLASH_MODE_EN
        ,FLASH    = 3'd6
`endif
    } phase_t;

    phase_t state;
    phase_t nxt;
    logic   walk_pending;
    logic   exp_ok;
    logic   reload;
    logic   load;

    function automatic logic [3:0] duration(phase_t s);
        case (s)
            MAIN_YEL, SIDE_YEL: duration = YEL_VAL;
            WALK, SIDE_GRN:     duration = EXT_VAL;
`ifdef TRAFFIC_FLASH_MODE_EN
            FLASH:              duration = 4'd1;
`endif
            default:            duration = BASE_VAL;
        endcase
    endfunction

    // {main, side, walk}
    function automatic logic [6:0] lamps(phase_t s);
        case (s)
            MAIN_YEL: lamps = 7'b010_100_0;
            WALK:     lamps = 7'b100_100_1;
            SIDE_GRN: lamps = 7'b100_001_0;
            SIDE_YEL: lamps = 7'b100_010_0;
`ifdef TRAFFIC_FLASH_MODE_EN
            FLASH:    lamps = 7'b010_100_0;
`endif
            default:  lamps = 7'b001_100_0;
        endcase
    endfunction

`ifdef TRAFFIC_FLASH_MODE_EN
    logic blink;
    logic blink_nxt;
`else
    logic unused_night;
    assign unused_night = night_mode;
`endif

    always_comb begin
        exp_ok = expired && !start_timer;
        nxt    = state;
        reload = 1'b0;
        case (state)
            MAIN_GRN:  if (exp_ok) nxt = MAIN_HOLD;
            MAIN_HOLD: begin
`ifdef TRAFFIC_FLASH_MODE_EN
                if (night_mode) nxt = FLASH;
                else
`endif
                if (sensor || walk_pending) nxt = MAIN_YEL;
            end
            MAIN_YEL:  if (exp_ok) nxt = walk_pending ? WALK : SIDE_GRN;
            WALK:      if (exp_ok) nxt = sensor ? SIDE_GRN : MAIN_GRN;
            SIDE_GRN:  if (exp_ok) nxt = SIDE_YEL;
            SIDE_YEL:  if (exp_ok) nxt = MAIN_GRN;
`ifdef TRAFFIC_FLASH_MODE_EN
            FLASH: begin
                if (exp_ok) begin
                    if (!night_mode) nxt = MAIN_GRN;
                    else             reload = 1'b1;
                end
            end
`endif
            default:   nxt = MAIN_GRN;
        endcase
        load = ((nxt != state) && (nxt != MAIN_HOLD)) || reload;
`ifdef TRAFFIC_FLASH_MODE_EN
        blink_nxt = blink;
        if (nxt == FLASH) begin
            if (state != FLASH) blink_nxt = 1'b1;
            else if (exp_ok)    blink_nxt = !blink;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state        <= MAIN_GRN;
            start_timer  <= 1'b1;
            timer_value  <= BASE_VAL;
            main_lights  <= 3'b001;
            side_lights  <= 3'b100;
            walk         <= 1'b0;
            walk_pending <= 1'b0;
`ifdef TRAFFIC_FLASH_MODE_EN
            blink        <= 1'b0;
`endif
        end else begin
            state       <= nxt;
            start_timer <= load;
            if (load) timer_value <= duration(nxt);
            {main_lights, side_lights, walk} <= lamps(nxt);
            // The request seen on the edge entering WALK counts as served.
            walk_pending <= (nxt == WALK && state != WALK) ? 1'b0 : (walk_pending | walk_request);
`ifdef TRAFFIC_FLASH_MODE_EN
            blink <= blink_nxt;
            if (nxt == FLASH && !blink_nxt) {main_lights, side_lights, walk} <= 7'b000_000_0;
`endif
        end
    end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: lockstep phase-table model plus a tick-counting timer model.
module tb_traffic_phase_controller;

    localparam int T_BASE = 6;
    localparam int T_EXT  = 4;
    localparam int T_YEL  = 2;
    localparam int PH_MG = 0, PH_MH = 1, PH_MY = 2, PH_WK = 3, PH_SG = 4, PH_SY = 5, PH_FL = 6;

    logic       clk = 1'b0;
    logic       sys_reset, sensor, walk_request, night_mode, expired;
    logic       start_timer;
    logic [3:0] timer_value;
    logic [2:0] main_lights, side_lights;
    logic       walk;

    always #5 clk = ~clk;

    traffic_phase_controller #(.T_BASE(T_BASE), .T_EXT(T_EXT), .T_YEL(T_YEL)) dut (
        .clk(clk), .sys_reset(sys_reset), .sensor(sensor), .walk_request(walk_request),
        .night_mode(night_mode), .expired(expired), .start_timer(start_timer),
        .timer_value(timer_value), .main_lights(main_lights), .side_lights(side_lights),
        .walk(walk)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase index into lamp / duration tables.
    int         m_ph;
    bit         m_start;
    logic [3:0] m_val;
    bit         m_pend;
    bit         m_blink;
    logic [2:0] main_tbl [7] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b010};
    logic [2:0] side_tbl [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    int         dur      [7] = '{T_BASE, 0, T_YEL, T_EXT, T_EXT, T_YEL, 1};

    int t_cnt;
    bit t_run;
    bit rand_tick;
    bit spur;

    task automatic model_step();
        bit ok;
        bit reload;
        int nph;
        if (sys_reset) begin
            m_ph = PH_MG; m_start = 1; m_val = 4'(T_BASE); m_pend = 0; m_blink = 0;
            return;
        end
        ok = expired && !m_start;
        nph = m_ph;
        reload = 0;
        case (m_ph)
            PH_MG: if (ok) nph = PH_MH;
            PH_MH: begin
`ifdef TRAFFIC_FLASH_MODE_EN
                if (night_mode) nph = PH_FL;
                else
`endif
                if (sensor || m_pend) nph = PH_MY;
            end
            PH_MY: if (ok) nph = m_pend ? PH_WK : PH_SG;
            PH_WK: if (ok) nph = sensor ? PH_SG : PH_MG;
            PH_SG: if (ok) nph = PH_SY;
            PH_SY: if (ok) nph = PH_MG;
            PH_FL: if (ok) begin
                if (!night_mode) nph = PH_MG;
                else begin reload = 1; m_blink = !m_blink; end
            end
            default: nph = PH_MG;
        endcase
        m_pend = (nph == PH_WK && m_ph != PH_WK) ? 1'b0 : (m_pend || walk_request);
        if (nph == PH_FL && m_ph != PH_FL) m_blink = 1;
        m_start = (nph != m_ph && dur[nph] != 0) || reload;
        if (m_start) m_val = 4'(dur[nph]);
        m_ph = nph;
    endtask

    task automatic compare();
        logic [2:0] em, es;
        bit ew, dark;
        em = main_tbl[m_ph];
        es = side_tbl[m_ph];
        ew = (m_ph == PH_WK);
        if (m_ph == PH_FL && !m_blink) begin em = 3'b000; es = 3'b000; end
        checks++;
        if (start_timer !== m_start) begin
            errors++; $display("FAIL start_timer got %b want %b at %0t", start_timer, m_start, $time);
        end
        checks++;
        if (timer_value !== m_val) begin
            errors++; $display("FAIL timer_value got %0d want %0d at %0t", timer_value, m_val, $time);
        end
        checks++;
        if (main_lights !== em) begin
            errors++; $display("FAIL main_lights got %b want %b at %0t", main_lights, em, $time);
        end
        checks++;
        if (side_lights !== es) begin
            errors++; $display("FAIL side_lights got %b want %b at %0t", side_lights, es, $time);
        end
        checks++;
        if (walk !== ew) begin
            errors++; $display("FAIL walk got %b want %b at %0t", walk, ew, $time);
        end
        checks++;
        if (dut.walk_pending !== m_pend) begin
            errors++; $display("FAIL walk_pending got %b want %b at %0t", dut.walk_pending, m_pend, $time);
        end
        dark = (main_lights == 3'b000) && (side_lights == 3'b000);
        if (!dark) begin
            checks++;
            if (!$onehot(main_lights) || !$onehot(side_lights)) begin
                errors++; $display("FAIL onehot got %b/%b at %0t", main_lights, side_lights, $time);
            end
            checks++;
            if (main_lights != 3'b100 && side_lights != 3'b100) begin
                errors++; $display("FAIL conflict got %b/%b want one red at %0t", main_lights, side_lights, $time);
            end
        end
        checks++;
        if (walk && !(main_lights == 3'b100 && side_lights == 3'b100)) begin
            errors++; $display("FAIL walk_safety got %b/%b want 100/100 at %0t", main_lights, side_lights, $time);
        end
    endtask

    task automatic drive_timer();
        if (m_start) begin
            t_cnt = int'(m_val); t_run = 1;
            expired = spur && ($urandom_range(0, 3) == 0);
        end else if (t_run) begin
            expired = 1'b0;
            if (!rand_tick || $urandom_range(0, 2) != 0) begin
                t_cnt--;
                if (t_cnt == 0) begin expired = 1'b1; t_run = 0; end
            end
        end else begin
            expired = spur && m_ph == PH_MH && ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
        drive_timer();
    endtask

    task automatic wait_phase(input int ph, input int budget, input string tag);
        int n = 0;
        while (m_ph != ph && n < budget) begin cycle(); n++; end
        checks++;
        if (m_ph != ph) begin
            errors++; $display("FAIL %s timeout phase got %0d want %0d", tag, m_ph, ph);
        end
    endtask

    task automatic test_reset();
        sys_reset = 1; expired = 0;
        repeat (3) cycle();
        sys_reset = 0;
        checks++;
        if (start_timer !== 1'b1 || timer_value !== 4'd6) begin
            errors++; $display("FAIL reset_load got %b/%0d want 1/6", start_timer, timer_value);
        end
        checks++;
        if (main_lights !== 3'b001 || side_lights !== 3'b100 || walk !== 1'b0) begin
            errors++; $display("FAIL reset_lamps got %b/%b/%b want 001/100/0", main_lights, side_lights, walk);
        end
        cycle();
        checks++;
        if (start_timer !== 1'b0) begin
            errors++; $display("FAIL reset_pulse_width got %b want 0", start_timer);
        end
    endtask

    task automatic test_main_hold();
        int pulses = 0;
        wait_phase(PH_MH, 40, "to_hold");
        repeat (120) begin cycle(); if (start_timer) pulses++; end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL hold_no_load got %0d want 0", pulses);
        end
        checks++;
        if (main_lights !== 3'b001 || side_lights !== 3'b100) begin
            errors++; $display("FAIL hold_lamps got %b/%b want 001/100", main_lights, side_lights);
        end
    endtask

    task automatic test_side_cycle();
        int exp_vals [4] = '{2, 4, 2, 6};
        int q[$];
        int n = 0;
        sensor = 1;
        cycle();
        checks++;
        if (main_lights !== 3'b010 || start_timer !== 1'b1 || timer_value !== 4'd2) begin
            errors++; $display("FAIL side_enter_yel got %b/%b/%0d want 010/1/2", main_lights, start_timer, timer_value);
        end
        q.push_back(int'(timer_value));
        while (q.size() < 4 && n < 100) begin
            cycle(); n++;
            if (start_timer) q.push_back(int'(timer_value));
        end
        sensor = 0;
        checks++;
        if (q.size() != 4) begin
            errors++; $display("FAIL side_seq_len got %0d want 4", q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q[i] != exp_vals[i]) begin
                    errors++; $display("FAIL side_seq[%0d] got %0d want %0d", i, q[i], exp_vals[i]);
                end
            end
        end
    endtask

    task automatic test_walk_pulse();
        walk_request = 1;
        cycle();
        walk_request = 0;
        checks++;
        if (dut.walk_pending !== 1'b1) begin
            errors++; $display("FAIL walk_latch got %b want 1", dut.walk_pending);
        end
        wait_phase(PH_WK, 80, "to_walk");
        checks++;
        if (walk !== 1'b1 || main_lights !== 3'b100 || side_lights !== 3'b100 ||
            start_timer !== 1'b1 || timer_value !== 4'd4 || dut.walk_pending !== 1'b0) begin
            errors++; $display("FAIL walk_entry got %b %b/%b %b/%0d pend %b want 1 100/100 1/4 pend 0",
                               walk, main_lights, side_lights, start_timer, timer_value, dut.walk_pending);
        end
        wait_phase(PH_MG, 40, "walk_to_main");
        checks++;
        if (main_lights !== 3'b001 || side_lights !== 3'b100 || start_timer !== 1'b1 || timer_value !== 4'd6) begin
            errors++; $display("FAIL walk_exit got %b/%b %b/%0d want 001/100 1/6", main_lights, side_lights, start_timer, timer_value);
        end
    endtask

    task automatic test_walk_held();
        int walk_cycles = 0;
        walk_request = 1;
        wait_phase(PH_WK, 80, "held_to_walk");
        walk_request = 0;
        cycle();
        cycle();
        checks++;
        if (dut.walk_pending !== 1'b0 || walk !== 1'b1) begin
            errors++; $display("FAIL held_served_once got pend %b walk %b want 0 1", dut.walk_pending, walk);
        end
        walk_request = 1;
        cycle();
        walk_request = 0;
        checks++;
        if (dut.walk_pending !== 1'b1 || walk !== 1'b1) begin
            errors++; $display("FAIL walk_during_walk got pend %b walk %b want 1 1", dut.walk_pending, walk);
        end
        wait_phase(PH_MG, 40, "held_to_main");
        wait_phase(PH_WK, 80, "second_walk");
        wait_phase(PH_MH, 60, "after_second_walk");
        repeat (40) begin cycle(); if (walk) walk_cycles++; end
        checks++;
        if (walk_cycles != 0) begin
            errors++; $display("FAIL no_third_walk got %0d want 0", walk_cycles);
        end
    endtask

    task automatic test_reset_mid();
        sensor = 1;
        wait_phase(PH_SG, 60, "to_side_grn");
        cycle();
        walk_request = 1;
        cycle();
        checks++;
        if (dut.walk_pending !== 1'b1 || side_lights !== 3'b001) begin
            errors++; $display("FAIL pre_reset got pend %b side %b want 1 001", dut.walk_pending, side_lights);
        end
        sys_reset = 1;
        expired = 1;
        cycle();
        sys_reset = 0;
        walk_request = 0;
        sensor = 0;
        checks++;
        if (main_lights !== 3'b001 || side_lights !== 3'b100 || start_timer !== 1'b1 ||
            timer_value !== 4'd6 || dut.walk_pending !== 1'b0) begin
            errors++; $display("FAIL mid_reset got %b/%b %b/%0d pend %b want 001/100 1/6 pend 0",
                               main_lights, side_lights, start_timer, timer_value, dut.walk_pending);
        end
    endtask

    task automatic test_night();
        int pulses = 0;
        wait_phase(PH_MH, 40, "night_to_hold");
        night_mode = 1;
`ifdef TRAFFIC_FLASH_MODE_EN
        cycle();
        checks++;
        if (main_lights !== 3'b010 || side_lights !== 3'b100 || start_timer !== 1'b1 || timer_value !== 4'd1) begin
            errors++; $display("FAIL flash_entry got %b/%b %b/%0d want 010/100 1/1", main_lights, side_lights, start_timer, timer_value);
        end
        cycle();
        cycle();
        checks++;
        if (main_lights !== 3'b000 || start_timer !== 1'b1 || timer_value !== 4'd1) begin
            errors++; $display("FAIL flash_toggle got %b %b/%0d want 000 1/1", main_lights, start_timer, timer_value);
        end
        repeat (8) cycle();
        night_mode = 0;
        wait_phase(PH_MG, 10, "flash_exit");
        checks++;
        if (main_lights !== 3'b001 || start_timer !== 1'b1 || timer_value !== 4'd6) begin
            errors++; $display("FAIL flash_exit got %b %b/%0d want 001 1/6", main_lights, start_timer, timer_value);
        end
`else
        repeat (40) begin cycle(); if (start_timer) pulses++; end
        night_mode = 0;
        checks++;
        if (main_lights !== 3'b001 || side_lights !== 3'b100 || pulses != 0) begin
            errors++; $display("FAIL night_ignored got %b/%b loads %0d want 001/100 loads 0", main_lights, side_lights, pulses);
        end
`endif
    endtask

    task automatic test_random();
        rand_tick = 1;
        spur = 1;
        repeat (4000) begin
            if ($urandom_range(0, 29) == 0) sensor = !sensor;
            if ($urandom_range(0, 149) == 0) night_mode = !night_mode;
            walk_request = ($urandom_range(0, 24) == 0);
            sys_reset = ($urandom_range(0, 599) == 0);
            cycle();
        end
        sys_reset = 0; walk_request = 0; sensor = 0; night_mode = 0;
        rand_tick = 0; spur = 0;
    endtask

    initial begin
        sys_reset = 1; sensor = 0; walk_request = 0; night_mode = 0; expired = 0;
        rand_tick = 0; spur = 0; t_cnt = 0; t_run = 0;
        m_ph = PH_MG; m_start = 1; m_val = 4'(T_BASE); m_pend = 0; m_blink = 0;
        test_reset();
        test_main_hold();
        test_side_cycle();
        test_walk_pulse();
        test_walk_held();
        test_reset_mid();
        test_night();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
